// File: rtl/alu_flag_if.sv
// Execute-to-flag-unit bundle: ALU results, branch requests, pipeline
// control, and the flag/branch/counter outputs back to the pipeline.
interface alu_flag_if;
  logic        ex_valid;
  logic [3:0]  alu_code;
  logic [15:0] alu_output;
  logic        overflow_flag;
  logic        zero_flag;
  logic        br_valid;
  logic [2:0]  br_ccc;
  logic        stall;
  logic        flush;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;
  logic        br_done;
  logic        br_taken;
  logic [15:0] upd_count;
  logic [15:0] taken_count;

  modport master (
    output ex_valid, alu_code, alu_output,
    output overflow_flag, zero_flag,
    output br_valid, br_ccc, stall, flush,
    input  flag_n, flag_z, flag_v,
    input  br_done, br_taken,
    input  upd_count, taken_count
  );

  modport slave (
    input  ex_valid, alu_code, alu_output,
    input  overflow_flag, zero_flag,
    input  br_valid, br_ccc, stall, flush,
    output flag_n, flag_z, flag_v,
    output br_done, br_taken,
    output upd_count, taken_count
  );
endinterface

// File: rtl/alu_flag_unit.sv
// N/Z/V flag register with same-cycle bypassed branch resolver
// and saturating update/taken event counters.
module alu_flag_unit (
  input logic       clk,
  input logic       rst,
  alu_flag_if.slave bus
);
  typedef enum logic {IDLE, DONE} state_t;

  state_t      state;
  logic        n_q, z_q, v_q;
  logic        done_q, taken_q;
  logic [15:0] upd_q, tkn_q;

  logic accept, br_acc;
  logic wr_nzv, wr_z;
  logic eff_n, eff_z, eff_v;
  logic cond;

  assign accept = bus.ex_valid & ~bus.stall & ~bus.flush;
  assign br_acc = bus.br_valid & ~bus.stall & ~bus.flush;

  always_comb begin
    wr_nzv = 1'b0;
    wr_z   = 1'b0;
    if (accept) begin
      unique case (bus.alu_code)
        4'b0000, 4'b0001: begin
          wr_nzv = 1'b1;
          wr_z   = 1'b1;
        end
        4'b0010, 4'b0100,
        4'b0101, 4'b0110: wr_z = 1'b1;
        default: ;
      endcase
    end
  end

  // Branch sees the flag value being written this cycle, if any
  assign eff_n = wr_nzv ? bus.alu_output[15] : n_q;
  assign eff_z = wr_z   ? bus.zero_flag      : z_q;
  assign eff_v = wr_nzv ? bus.overflow_flag  : v_q;

  always_comb begin
    cond = 1'b0;
    unique case (bus.br_ccc)
      3'b000: cond = ~eff_z;
      3'b001: cond = eff_z;
      3'b010: cond = ~eff_z & ~eff_n;
      3'b011: cond = eff_n;
      3'b100: cond = eff_z | ~eff_n;
      3'b101: cond = eff_n | eff_z;
      3'b110: cond = eff_v;
      3'b111: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      upd_q   <= '0;
      tkn_q   <= '0;
    end else begin
      if (wr_nzv) begin
        n_q <= bus.alu_output[15];
        v_q <= bus.overflow_flag;
      end
      if (wr_z)
        z_q <= bus.zero_flag;
      if (wr_z && upd_q != 16'hFFFF)
        upd_q <= upd_q + 16'd1;
      if (br_acc && cond && tkn_q != 16'hFFFF)
        tkn_q <= tkn_q + 16'd1;
      done_q <= br_acc;
      if (br_acc)
        taken_q <= cond;
      unique case (state)
        IDLE: if (br_acc) state <= DONE;
        DONE: if (br_acc) state <= DONE;
              else if (!bus.stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.flag_n      = n_q;
  assign bus.flag_z      = z_q;
  assign bus.flag_v      = v_q;
  assign bus.br_done     = done_q;
  assign bus.br_taken    = taken_q;
  assign bus.upd_count   = upd_q;
  assign bus.taken_count = tkn_q;
endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit: flag rules, bypass, conditions,
// stall/flush, async reset and counter saturation.
module tb_alu_flag_unit;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   exp_upd;
  int   exp_taken;

  alu_flag_if bus ();

  alu_flag_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [3:0] c,
                         input logic [15:0] o, input logic ov,
                         input logic z);
    bus.ex_valid      = v;
    bus.alu_code      = c;
    bus.alu_output    = o;
    bus.overflow_flag = ov;
    bus.zero_flag     = z;
  endtask

  task automatic set_br(input logic v, input logic [2:0] c);
    bus.br_valid = v;
    bus.br_ccc   = c;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_alu(0, 4'h0, 16'h0, 0, 0);
    set_br(0, 3'b000);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    #1;
    checks++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000",
               {bus.flag_n, bus.flag_z, bus.flag_v});
    end
    checks++;
    if ({bus.br_done, bus.br_taken} !== 2'b00) begin
      errors++;
      $display("FAIL reset_br got=%b exp=00",
               {bus.br_done, bus.br_taken});
    end
    checks++;
    if (bus.upd_count !== 16'h0 || bus.taken_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt got=%h/%h exp=0/0",
               bus.upd_count, bus.taken_count);
    end
    step();
    step();
    rst = 1'b0;
    exp_upd = 0;
    exp_taken = 0;
  endtask

  task automatic test_add_overflow;
    set_alu(1, 4'h0, 16'h7FFF, 1, 0);
    step();
    exp_upd++;
    set_alu(0, 4'h0, 16'h0, 0, 0);
    checks++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b001) begin
      errors++;
      $display("FAIL add_flags got=%b exp=001",
               {bus.flag_n, bus.flag_z, bus.flag_v});
    end
    checks++;
    if (bus.upd_count !== 16'd1) begin
      errors++;
      $display("FAIL add_upd got=%0d exp=1", bus.upd_count);
    end
    set_br(1, 3'b110);
    step();
    exp_taken++;
    set_br(0, 3'b000);
    checks++;
    if ({bus.br_done, bus.br_taken} !== 2'b11) begin
      errors++;
      $display("FAIL add_ov_branch got=%b exp=11",
               {bus.br_done, bus.br_taken});
    end
    step();
    checks++;
    if (bus.br_done !== 1'b0) begin
      errors++;
      $display("FAIL add_done_pulse got=%b exp=0", bus.br_done);
    end
  endtask

  task automatic test_xor_hold;
    set_alu(1, 4'h1, 16'h8000, 1, 0);
    step();
    exp_upd++;
    set_alu(1, 4'h2, 16'h0000, 0, 1);
    step();
    exp_upd++;
    set_alu(0, 4'h0, 16'h0, 0, 0);
    checks++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b111) begin
      errors++;
      $display("FAIL xor_flags got=%b exp=111",
               {bus.flag_n, bus.flag_z, bus.flag_v});
    end
    checks++;
    if (bus.upd_count !== exp_upd[15:0]) begin
      errors++;
      $display("FAIL xor_upd got=%0d exp=%0d", bus.upd_count, exp_upd);
    end
    set_br(1, 3'b001);
    step();
    exp_taken++;
    set_br(0, 3'b000);
    checks++;
    if ({bus.br_done, bus.br_taken} !== 2'b11) begin
      errors++;
      $display("FAIL xor_eq_branch got=%b exp=11",
               {bus.br_done, bus.br_taken});
    end
    step();
  endtask

  task automatic test_bypass;
    set_alu(1, 4'h0, 16'h0001, 0, 0);
    step();
    exp_upd++;
    set_alu(1, 4'h1, 16'h8001, 0, 0);
    set_br(1, 3'b011);
    step();
    exp_upd++;
    exp_taken++;
    checks++;
    if ({bus.br_done, bus.br_taken} !== 2'b11) begin
      errors++;
      $display("FAIL bypass_lt got=%b exp=11",
               {bus.br_done, bus.br_taken});
    end
    checks++;
    if (bus.taken_count !== exp_taken[15:0] || bus.flag_n !== 1'b1) begin
      errors++;
      $display("FAIL bypass_cnt got=%0d/%b exp=%0d/1",
               bus.taken_count, bus.flag_n, exp_taken);
    end
    set_alu(1, 4'h0, 16'h0000, 0, 1);
    set_br(1, 3'b000);
    step();
    exp_upd++;
    set_alu(0, 4'h0, 16'h0, 0, 0);
    set_br(0, 3'b000);
    checks++;
    if ({bus.br_done, bus.br_taken} !== 2'b10) begin
      errors++;
      $display("FAIL bypass_ne got=%b exp=10",
               {bus.br_done, bus.br_taken});
    end
    checks++;
    if (bus.taken_count !== exp_taken[15:0]) begin
      errors++;
      $display("FAIL bypass_ne_cnt got=%0d exp=%0d",
               bus.taken_count, exp_taken);
    end
    step();
  endtask

  task automatic test_conditions;
    logic [15:0] outs [3];
    logic        ovs  [3];
    logic        zs   [3];
    logic [7:0]  mask [3];
    outs[0] = 16'h0001; ovs[0] = 0; zs[0] = 0; mask[0] = 8'h95;
    outs[1] = 16'h8000; ovs[1] = 1; zs[1] = 0; mask[1] = 8'hE9;
    outs[2] = 16'h0000; ovs[2] = 0; zs[2] = 1; mask[2] = 8'hB2;
    for (int s = 0; s < 3; s++) begin
      set_alu(1, 4'h0, outs[s], ovs[s], zs[s]);
      step();
      exp_upd++;
      set_alu(0, 4'h0, 16'h0, 0, 0);
      for (int c = 0; c < 8; c++) begin
        set_br(1, 3'(c));
        step();
        if (mask[s][c]) exp_taken++;
        checks++;
        if (bus.br_done !== 1'b1 || bus.br_taken !== mask[s][c]) begin
          errors++;
          $display("FAIL cond s%0d ccc%0d got=%b%b exp=1%b",
                   s, c, bus.br_done, bus.br_taken, mask[s][c]);
        end
      end
      set_br(0, 3'b000);
      step();
    end
    checks++;
    if (bus.taken_count !== exp_taken[15:0] ||
        bus.upd_count !== exp_upd[15:0]) begin
      errors++;
      $display("FAIL cond_cnt got=%0d/%0d exp=%0d/%0d",
               bus.taken_count, bus.upd_count, exp_taken, exp_upd);
    end
  endtask

  task automatic test_stall;
    bus.stall = 1'b1;
    set_alu(1, 4'h0, 16'h7FFF, 1, 0);
    set_br(1, 3'b111);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.flag_n, bus.flag_z, bus.flag_v, bus.br_done} !== 4'b0100 ||
          bus.upd_count !== exp_upd[15:0] ||
          bus.taken_count !== exp_taken[15:0]) begin
        errors++;
        $display("FAIL stall_hold%0d got=%b%b%b%b %0d/%0d exp=0100 %0d/%0d",
                 i, bus.flag_n, bus.flag_z, bus.flag_v, bus.br_done,
                 bus.upd_count, bus.taken_count, exp_upd, exp_taken);
      end
    end
    bus.stall = 1'b0;
    step();
    exp_upd++;
    exp_taken++;
    set_alu(0, 4'h0, 16'h0, 0, 0);
    set_br(0, 3'b000);
    checks++;
    if ({bus.br_done, bus.br_taken} !== 2'b11 ||
        {bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b001) begin
      errors++;
      $display("FAIL stall_release got=%b%b %b%b%b exp=11 001",
               bus.br_done, bus.br_taken,
               bus.flag_n, bus.flag_z, bus.flag_v);
    end
    step();
    checks++;
    if (bus.br_done !== 1'b0) begin
      errors++;
      $display("FAIL stall_single_pulse got=%b exp=0", bus.br_done);
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 2; i++) begin
      bus.flush = 1'b1;
      bus.stall = logic'(i);
      set_alu(1, 4'h1, 16'h8000, 0, 1);
      set_br(1, 3'b111);
      step();
      checks++;
      if ({bus.flag_n, bus.flag_z, bus.flag_v, bus.br_done} !== 4'b0010 ||
          bus.upd_count !== exp_upd[15:0] ||
          bus.taken_count !== exp_taken[15:0]) begin
        errors++;
        $display("FAIL flush%0d got=%b%b%b%b %0d/%0d exp=0010 %0d/%0d",
                 i, bus.flag_n, bus.flag_z, bus.flag_v, bus.br_done,
                 bus.upd_count, bus.taken_count, exp_upd, exp_taken);
      end
    end
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    set_alu(1, 4'h3, 16'h8000, 1, 1);
    set_br(0, 3'b000);
    step();
    set_alu(1, 4'h8, 16'h8000, 1, 1);
    step();
    set_alu(0, 4'h0, 16'h0, 0, 0);
    checks++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b001 ||
        bus.upd_count !== exp_upd[15:0]) begin
      errors++;
      $display("FAIL red_nowrite got=%b%b%b %0d exp=001 %0d",
               bus.flag_n, bus.flag_z, bus.flag_v,
               bus.upd_count, exp_upd);
    end
  endtask

  task automatic test_reset_mid;
    set_br(1, 3'b111);
    step();
    set_br(0, 3'b000);
    checks++;
    if (bus.br_done !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_done got=%b exp=1", bus.br_done);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v,
         bus.br_done, bus.br_taken} !== 5'b0 ||
        bus.upd_count !== 16'h0 || bus.taken_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid got=%b%b%b%b%b %h/%h exp=00000 0/0",
               bus.flag_n, bus.flag_z, bus.flag_v, bus.br_done,
               bus.br_taken, bus.upd_count, bus.taken_count);
    end
    step();
    rst = 1'b0;
    exp_upd = 0;
    exp_taken = 0;
  endtask

  task automatic test_saturate;
    set_br(1, 3'b111);
    repeat (65535) step();
    checks++;
    if (bus.taken_count !== 16'hFFFF || bus.br_done !== 1'b1) begin
      errors++;
      $display("FAIL sat_reach got=%h/%b exp=ffff/1",
               bus.taken_count, bus.br_done);
    end
    step();
    checks++;
    if (bus.taken_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold got=%h exp=ffff", bus.taken_count);
    end
    set_br(0, 3'b000);
    set_alu(1, 4'h1, 16'h0005, 0, 0);
    step();
    set_alu(1, 4'h7, 16'h0000, 0, 1);
    step();
    set_alu(0, 4'h0, 16'h0, 0, 0);
    checks++;
    if (bus.upd_count !== 16'd1 || bus.flag_z !== 1'b0) begin
      errors++;
      $display("FAIL paddsb_nowrite got=%0d/%b exp=1/0",
               bus.upd_count, bus.flag_z);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add_overflow();
    test_xor_hold();
    test_bypass();
    test_conditions();
    test_stall();
    test_flush();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
